// File: rtl/modulo_controle_jogo.sv
// Game controller for a two-matrix battleship board: debounced-edge button events drive
// a placement/attack/check FSM that tracks the attack coordinate, hits, shots and the outcome.
module modulo_controle_jogo #(
    parameter int SHIP_CELLS = 9,
    parameter int MAX_SHOTS  = 20
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       button_confirmation,
    input  logic       button_count,
    input  logic       hit_in,
    input  logic       attacked_in,
    output logic [1:0] game_state,
    output logic       clr_mats,
    output logic       po_load,
    output logic       at_we,
    output logic [2:0] at_row,
    output logic [2:0] at_col,
    output logic [1:0] rgb_output,
    output logic [3:0] hits,
    output logic [4:0] shots,
    output logic       win,
    output logic       lose
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_POSICAO = 3'd1,
        S_ATAQUE  = 3'd2,
        S_CHECA   = 3'd3,
        S_FIM     = 3'd4
    } state_t;

    localparam logic [3:0] HITS_MAX  = 4'(SHIP_CELLS);
    localparam logic [4:0] SHOTS_MAX = 5'(MAX_SHOTS);
    localparam logic [2:0] ROW_LAST  = 3'd6;
    localparam logic [2:0] COL_LAST  = 3'd4;

    localparam logic [1:0] RGB_NONE = 2'b00;
    localparam logic [1:0] RGB_MISS = 2'b01;
    localparam logic [1:0] RGB_HIT  = 2'b10;
    localparam logic [1:0] RGB_REP  = 2'b11;

    // Button front end: two synchronizer stages plus the previous synchronized level.
    logic       conf_s1_q, conf_s1_d, conf_s2_q, conf_s2_d, conf_prev_q, conf_prev_d;
    logic       cnt_s1_q, cnt_s1_d, cnt_s2_q, cnt_s2_d, cnt_prev_q, cnt_prev_d;
    logic       conf_armed_q, conf_armed_d, cnt_armed_q, cnt_armed_d;
    logic [1:0] init_q, init_d;
    logic       conf_ev, cnt_ev;

    // A button only becomes armed once the filled synchronizer has seen it released,
    // so a button held across reset release never produces an event.
    always_comb begin
        conf_s1_d    = button_confirmation;
        conf_s2_d    = conf_s1_q;
        conf_prev_d  = conf_s2_q;
        cnt_s1_d     = button_count;
        cnt_s2_d     = cnt_s1_q;
        cnt_prev_d   = cnt_s2_q;
        init_d       = {init_q[0], 1'b1};
        conf_armed_d = conf_armed_q | (init_q[1] & ~conf_s2_q);
        cnt_armed_d  = cnt_armed_q  | (init_q[1] & ~cnt_s2_q);
        conf_ev      = conf_s2_q & ~conf_prev_q & conf_armed_q;
        cnt_ev       = cnt_s2_q  & ~cnt_prev_q  & cnt_armed_q;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            conf_s1_q    <= 1'b0;
            conf_s2_q    <= 1'b0;
            conf_prev_q  <= 1'b0;
            cnt_s1_q     <= 1'b0;
            cnt_s2_q     <= 1'b0;
            cnt_prev_q   <= 1'b0;
            conf_armed_q <= 1'b0;
            cnt_armed_q  <= 1'b0;
            init_q       <= 2'b00;
        end else begin
            conf_s1_q    <= conf_s1_d;
            conf_s2_q    <= conf_s2_d;
            conf_prev_q  <= conf_prev_d;
            cnt_s1_q     <= cnt_s1_d;
            cnt_s2_q     <= cnt_s2_d;
            cnt_prev_q   <= cnt_prev_d;
            conf_armed_q <= conf_armed_d;
            cnt_armed_q  <= cnt_armed_d;
            init_q       <= init_d;
        end
    end

    state_t     state_q, state_d;
    logic [2:0] row_q, row_d, col_q, col_d;
    logic [3:0] hits_q, hits_d, hits_nxt;
    logic [4:0] shots_q, shots_d, shots_nxt;
    logic [1:0] rgb_q, rgb_d;
    logic       win_q, win_d, lose_q, lose_d;
    logic       clr_mats_q, clr_mats_d, po_load_q, po_load_d;

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        hits_d     = hits_q;
        shots_d    = shots_q;
        rgb_d      = rgb_q;
        win_d      = win_q;
        lose_d     = lose_q;
        clr_mats_d = 1'b0;
        po_load_d  = 1'b0;
        hits_nxt   = (hit_in && (hits_q != HITS_MAX)) ? hits_q + 4'd1 : hits_q;
        shots_nxt  = (shots_q != SHOTS_MAX) ? shots_q + 5'd1 : shots_q;

        case (state_q)
            S_IDLE: begin
                if (conf_ev) begin
                    state_d    = S_POSICAO;
                    clr_mats_d = 1'b1;
                    hits_d     = 4'd0;
                    shots_d    = 5'd0;
                    rgb_d      = RGB_NONE;
                    row_d      = 3'd0;
                    col_d      = 3'd0;
                    win_d      = 1'b0;
                    lose_d     = 1'b0;
                end
            end
            S_POSICAO: begin
                if (conf_ev) begin
                    state_d   = S_ATAQUE;
                    po_load_d = 1'b1;
                end
            end
            S_ATAQUE: begin
                // Confirm outranks a simultaneous count event.
                if (conf_ev) begin
                    state_d = S_CHECA;
                end else if (cnt_ev) begin
                    if (row_q == ROW_LAST) begin
                        row_d = 3'd0;
                        col_d = (col_q == COL_LAST) ? 3'd0 : col_q + 3'd1;
                    end else begin
                        row_d = row_q + 3'd1;
                    end
                end
            end
            S_CHECA: begin
                if (attacked_in) begin
                    rgb_d   = RGB_REP;
                    state_d = S_ATAQUE;
                end else begin
                    hits_d  = hits_nxt;
                    shots_d = shots_nxt;
                    rgb_d   = hit_in ? RGB_HIT : RGB_MISS;
                    if (hits_nxt == HITS_MAX) begin
                        state_d = S_FIM;
                        win_d   = 1'b1;
                    end else if (shots_nxt == SHOTS_MAX) begin
                        state_d = S_FIM;
                        lose_d  = 1'b1;
                    end else begin
                        state_d = S_ATAQUE;
                    end
                end
            end
            S_FIM: begin
                if (conf_ev) begin
                    state_d    = S_IDLE;
                    clr_mats_d = 1'b1;
                    win_d      = 1'b0;
                    lose_d     = 1'b0;
                    rgb_d      = RGB_NONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= S_IDLE;
            row_q      <= 3'd0;
            col_q      <= 3'd0;
            hits_q     <= 4'd0;
            shots_q    <= 5'd0;
            rgb_q      <= RGB_NONE;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
            clr_mats_q <= 1'b0;
            po_load_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            hits_q     <= hits_d;
            shots_q    <= shots_d;
            rgb_q      <= rgb_d;
            win_q      <= win_d;
            lose_q     <= lose_d;
            clr_mats_q <= clr_mats_d;
            po_load_q  <= po_load_d;
        end
    end

    always_comb begin
        case (state_q)
            S_POSICAO:         game_state = 2'b01;
            S_ATAQUE, S_CHECA: game_state = 2'b10;
            S_FIM:             game_state = 2'b11;
            default:           game_state = 2'b00;
        endcase
    end

    // The attack-matrix write happens during the single CHECA cycle for a fresh cell only.
    assign at_we      = (state_q == S_CHECA) & ~attacked_in;
    assign clr_mats   = clr_mats_q;
    assign po_load    = po_load_q;
    assign at_row     = row_q;
    assign at_col     = col_q;
    assign rgb_output = rgb_q;
    assign hits       = hits_q;
    assign shots      = shots_q;
    assign win        = win_q;
    assign lose       = lose_q;

endmodule

// File: tb/tb_modulo_controle_jogo.sv
// Directed bench for modulo_controle_jogo with SHIP_CELLS=2, MAX_SHOTS=2 so that win and
// lose are reachable in a couple of shots.
module tb_modulo_controle_jogo;

    logic       clk = 1'b0;
    logic       clr;
    logic       bconf, bcnt, hit_in, attacked_in;
    logic [1:0] game_state, rgb_output;
    logic       clr_mats, po_load, at_we, win, lose;
    logic [2:0] at_row, at_col;
    logic [3:0] hits;
    logic [4:0] shots;

    int n_vec  = 0;
    int n_err  = 0;
    int we_cnt = 0;

    modulo_controle_jogo #(.SHIP_CELLS(2), .MAX_SHOTS(2)) dut (
        .clk                 (clk),
        .clr                 (clr),
        .button_confirmation (bconf),
        .button_count        (bcnt),
        .hit_in              (hit_in),
        .attacked_in         (attacked_in),
        .game_state          (game_state),
        .clr_mats            (clr_mats),
        .po_load             (po_load),
        .at_we               (at_we),
        .at_row              (at_row),
        .at_col              (at_col),
        .rgb_output          (rgb_output),
        .hits                (hits),
        .shots               (shots),
        .win                 (win),
        .lose                (lose)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (at_we === 1'b1) we_cnt++;

    task automatic do_reset;
        clr = 1'b0; bconf = 1'b0; bcnt = 1'b0; hit_in = 1'b0; attacked_in = 1'b0;
        repeat (2) @(negedge clk);
        clr = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    // Raise the buttons, return #1 after the third sampling edge (the event edge).
    task automatic press(input logic c, input logic k);
        @(negedge clk);
        bconf = c; bcnt = k;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic release_all;
        @(negedge clk);
        bconf = 1'b0; bcnt = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic count_n(input int n);
        for (int i = 0; i < n; i++) begin
            press(1'b0, 1'b1);
            release_all();
        end
    endtask

    task automatic goto_attack;
        press(1'b1, 1'b0); release_all();
        press(1'b1, 1'b0); release_all();
    endtask

    task automatic shoot(input logic h, input logic a);
        hit_in = h; attacked_in = a;
        press(1'b1, 1'b0);
        @(posedge clk); #1;
        release_all();
    endtask

    task automatic test_reset;
        clr = 1'b0;
        repeat (2) @(negedge clk);
        if ({game_state, clr_mats, po_load, at_we, at_row, at_col, rgb_output, hits, shots, win, lose} !== 24'h0) begin
            $display("FAIL reset_outputs got %h want 0", {game_state, clr_mats, po_load, at_we, at_row, at_col, rgb_output, hits, shots, win, lose});
            n_err++;
        end
        n_vec++;
        do_reset();
    endtask

    task automatic test_start;
        press(1'b1, 1'b0);
        if (game_state !== 2'b01) begin $display("FAIL start_pos_state got %b want 01", game_state); n_err++; end
        n_vec++;
        if (clr_mats !== 1'b1) begin $display("FAIL start_clr_mats got %b want 1", clr_mats); n_err++; end
        n_vec++;
        if (po_load !== 1'b0) begin $display("FAIL start_po_load_idle got %b want 0", po_load); n_err++; end
        n_vec++;
        @(posedge clk); #1;
        if (clr_mats !== 1'b0) begin $display("FAIL start_clr_mats_pulse got %b want 0", clr_mats); n_err++; end
        n_vec++;
        release_all();
        press(1'b0, 1'b1);
        release_all();
        if ({game_state, at_row} !== 5'b01_000) begin $display("FAIL pos_count_ignored got %b want 01000", {game_state, at_row}); n_err++; end
        n_vec++;
        press(1'b1, 1'b0);
        if (game_state !== 2'b10) begin $display("FAIL start_atk_state got %b want 10", game_state); n_err++; end
        n_vec++;
        if (po_load !== 1'b1) begin $display("FAIL start_po_load got %b want 1", po_load); n_err++; end
        n_vec++;
        if ({at_row, at_col} !== 6'o00) begin $display("FAIL start_coord got %o want 00", {at_row, at_col}); n_err++; end
        n_vec++;
        @(posedge clk); #1;
        if (po_load !== 1'b0) begin $display("FAIL start_po_load_pulse got %b want 0", po_load); n_err++; end
        n_vec++;
        release_all();
    endtask

    task automatic test_coord;
        count_n(3);
        if ({at_row, at_col} !== 6'o30) begin $display("FAIL coord_3 got %o want 30", {at_row, at_col}); n_err++; end
        n_vec++;
        count_n(4);
        if ({at_row, at_col} !== 6'o01) begin $display("FAIL coord_7 got %o want 01", {at_row, at_col}); n_err++; end
        n_vec++;
        count_n(27);
        if ({at_row, at_col} !== 6'o64) begin $display("FAIL coord_34 got %o want 64", {at_row, at_col}); n_err++; end
        n_vec++;
        count_n(1);
        if ({at_row, at_col} !== 6'o00) begin $display("FAIL coord_35 got %o want 00", {at_row, at_col}); n_err++; end
        n_vec++;
    endtask

    task automatic test_shot;
        we_cnt = 0;
        hit_in = 1'b1; attacked_in = 1'b0;
        press(1'b1, 1'b0);
        if ({game_state, at_we} !== 3'b10_1) begin $display("FAIL shot_checa_we got %b want 101", {game_state, at_we}); n_err++; end
        n_vec++;
        @(posedge clk); #1;
        if ({at_we, hits, shots, rgb_output, game_state} !== {1'b0, 4'd1, 5'd1, 2'b10, 2'b10}) begin
            $display("FAIL shot_hit_result got %h want %h", {at_we, hits, shots, rgb_output, game_state}, {1'b0, 4'd1, 5'd1, 2'b10, 2'b10});
            n_err++;
        end
        n_vec++;
        release_all();
        if (we_cnt !== 1) begin $display("FAIL shot_we_count got %0d want 1", we_cnt); n_err++; end
        n_vec++;
        we_cnt = 0;
        attacked_in = 1'b1;
        press(1'b1, 1'b0);
        if (at_we !== 1'b0) begin $display("FAIL shot_repeat_we got %b want 0", at_we); n_err++; end
        n_vec++;
        @(posedge clk); #1;
        if ({hits, shots, rgb_output, game_state} !== {4'd1, 5'd1, 2'b11, 2'b10}) begin
            $display("FAIL shot_repeat_result got %h want %h", {hits, shots, rgb_output, game_state}, {4'd1, 5'd1, 2'b11, 2'b10});
            n_err++;
        end
        n_vec++;
        release_all();
        if (we_cnt !== 0) begin $display("FAIL shot_repeat_we_count got %0d want 0", we_cnt); n_err++; end
        n_vec++;
    endtask

    task automatic test_lose;
        do_reset();
        goto_attack();
        shoot(1'b0, 1'b0);
        if ({hits, shots, rgb_output, game_state} !== {4'd0, 5'd1, 2'b01, 2'b10}) begin
            $display("FAIL lose_miss got %h want %h", {hits, shots, rgb_output, game_state}, {4'd0, 5'd1, 2'b01, 2'b10});
            n_err++;
        end
        n_vec++;
        shoot(1'b1, 1'b0);
        if ({win, lose, game_state, hits, shots, rgb_output} !== {1'b0, 1'b1, 2'b11, 4'd1, 5'd2, 2'b10}) begin
            $display("FAIL lose_end got %h want %h", {win, lose, game_state, hits, shots, rgb_output}, {1'b0, 1'b1, 2'b11, 4'd1, 5'd2, 2'b10});
            n_err++;
        end
        n_vec++;
        press(1'b0, 1'b1);
        release_all();
        if ({game_state, lose, at_row} !== {2'b11, 1'b1, 3'd0}) begin $display("FAIL fim_count_ignored got %b want 111000", {game_state, lose, at_row}); n_err++; end
        n_vec++;
        press(1'b1, 1'b0);
        if ({game_state, clr_mats, win, lose, rgb_output} !== {2'b00, 1'b1, 1'b0, 1'b0, 2'b00}) begin
            $display("FAIL lose_to_idle got %b want 0010000", {game_state, clr_mats, win, lose, rgb_output});
            n_err++;
        end
        n_vec++;
        release_all();
    endtask

    task automatic test_win;
        do_reset();
        goto_attack();
        shoot(1'b1, 1'b0);
        if ({game_state, win, hits} !== {2'b10, 1'b0, 4'd1}) begin $display("FAIL win_first_hit got %b want 1000001", {game_state, win, hits}); n_err++; end
        n_vec++;
        shoot(1'b1, 1'b0);
        if ({win, lose, game_state, hits, shots} !== {1'b1, 1'b0, 2'b11, 4'd2, 5'd2}) begin
            $display("FAIL win_end got %h want %h", {win, lose, game_state, hits, shots}, {1'b1, 1'b0, 2'b11, 4'd2, 5'd2});
            n_err++;
        end
        n_vec++;
        press(1'b1, 1'b0);
        if ({game_state, clr_mats, win} !== {2'b00, 1'b1, 1'b0}) begin $display("FAIL win_to_idle got %b want 0010", {game_state, clr_mats, win}); n_err++; end
        n_vec++;
        release_all();
    endtask

    task automatic test_back_to_back;
        do_reset();
        goto_attack();
        count_n(2);
        we_cnt = 0;
        hit_in = 1'b0; attacked_in = 1'b0;
        press(1'b1, 1'b1);
        if ({at_we, at_row, at_col} !== {1'b1, 3'd2, 3'd0}) begin $display("FAIL simul_confirm_wins got %b want 1010000", {at_we, at_row, at_col}); n_err++; end
        n_vec++;
        repeat (100) @(negedge clk);
        if ({we_cnt[3:0], shots, at_row, game_state} !== {4'd1, 5'd1, 3'd2, 2'b10}) begin
            $display("FAIL hold_single_event got %h want %h", {we_cnt[3:0], shots, at_row, game_state}, {4'd1, 5'd1, 3'd2, 2'b10});
            n_err++;
        end
        n_vec++;
        release_all();
    endtask

    task automatic test_reset_checa;
        do_reset();
        goto_attack();
        we_cnt = 0;
        hit_in = 1'b1; attacked_in = 1'b0;
        press(1'b1, 1'b0);
        if (at_we !== 1'b1) begin $display("FAIL rst_checa_pre got %b want 1", at_we); n_err++; end
        n_vec++;
        clr = 1'b0;
        #1;
        if ({game_state, clr_mats, po_load, at_we, at_row, at_col, rgb_output, hits, shots, win, lose} !== 24'h0) begin
            $display("FAIL rst_checa_outputs got %h want 0", {game_state, clr_mats, po_load, at_we, at_row, at_col, rgb_output, hits, shots, win, lose});
            n_err++;
        end
        n_vec++;
        repeat (2) @(negedge clk);
        clr = 1'b1;
        repeat (10) @(negedge clk);
        if ({game_state, clr_mats, we_cnt[3:0]} !== 7'b0) begin $display("FAIL rst_held_no_event got %b want 0", {game_state, clr_mats, we_cnt[3:0]}); n_err++; end
        n_vec++;
        release_all();
        press(1'b1, 1'b0);
        if (game_state !== 2'b01) begin $display("FAIL rst_new_press got %b want 01", game_state); n_err++; end
        n_vec++;
        release_all();
    endtask

    initial begin
        clr = 1'b1; bconf = 1'b0; bcnt = 1'b0; hit_in = 1'b0; attacked_in = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_start();
        test_coord();
        test_shot();
        test_lose();
        test_win();
        test_back_to_back();
        test_reset_checa();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/modulo_controle_jogo.md
MODULO_CONTROLE_JOGO -- requirements
Module: modulo_controle_jogo

Interface
REQ-001 SHALL have parameter SHIP_CELLS, default 9: number of occupied cells in every position preset (win threshold).
REQ-002 SHALL have parameter MAX_SHOTS, default 20: number of valid shots after which the game is lost.
REQ-003 SHALL have port clk  in  1: single system clock, rising-edge.
REQ-004 SHALL have port clr  in  1: reset, asynchronous, active-low.
REQ-005 SHALL have port button_confirmation  in  1: raw confirm button, high while pressed.
REQ-006 SHALL have port button_count  in  1: raw coordinate-advance button, high while pressed.
REQ-007 SHALL have port hit_in  in  1: position-matrix bit at (at_row, at_col), valid combinationally from the datapath.
REQ-008 SHALL have port attacked_in  in  1: attack-matrix bit at (at_row, at_col), valid combinationally from the datapath.
REQ-009 SHALL have port game_state  out  2: 00 idle, 01 position, 10 attack, 11 end; drives the datapath mode select.
REQ-010 SHALL have port clr_mats  out  1: one-cycle pulse clearing both matrix registers.
REQ-011 SHALL have port po_load  out  1: one-cycle pulse loading the selected preset into the position matrix.
REQ-012 SHALL have port at_we  out  1: one-cycle pulse writing the attack-matrix cell at (at_row, at_col).
REQ-013 SHALL have ports at_row  out  3 (0-6) and at_col  out  3 (0-4): current attack coordinate.
REQ-014 SHALL have port rgb_output  out  2: 00 none, 01 miss, 10 hit, 11 repeated cell.
REQ-015 SHALL have ports hits  out  4, shots  out  5, win  out  1, lose  out  1.

Function
REQ-016 Each button SHALL pass through a 2-flop synchronizer and a rising-edge detector; one press = one event; state changes on the 3rd clk edge at which the button is sampled high; holding a button SHALL NOT repeat.
REQ-017 FSM states SHALL be IDLE, POSICAO, ATAQUE, CHECA, FIM; game_state = 00 in IDLE, 01 in POSICAO, 10 in ATAQUE and CHECA, 11 in FIM.
REQ-018 IDLE: confirm event -> POSICAO, clr_mats pulse in the same transition cycle; hits, shots, rgb_output, coordinate cleared to 0.
REQ-019 POSICAO: confirm event -> ATAQUE with po_load pulse; count events ignored.
REQ-020 ATAQUE: count event advances row 0..6; row 6 wraps to 0 and col+1; (row 6, col 4) wraps to (0, 0).
REQ-021 ATAQUE: confirm event -> CHECA; confirm and count events in the same cycle: confirm wins, count discarded.
REQ-022 CHECA SHALL last exactly one cycle, sampling hit_in and attacked_in at its end.
REQ-023 CHECA with attacked_in=1: no at_we, counters unchanged, rgb_output=11, -> ATAQUE.
REQ-024 CHECA with attacked_in=0: at_we pulse during CHECA, shots+1, hits+1 if hit_in, rgb_output=10 if hit_in else 01.
REQ-025 After REQ-024: if new hits == SHIP_CELLS -> FIM with win=1; else if new shots == MAX_SHOTS -> FIM with lose=1; else -> ATAQUE; the win check SHALL take priority when both hold.
REQ-026 rgb_output SHALL hold its value until the next CHECA result or IDLE entry.
REQ-027 FIM: win/lose held; count events ignored; confirm event -> IDLE with clr_mats pulse, win=lose=0.
REQ-028 Counters SHALL saturate at SHIP_CELLS/MAX_SHOTS and never wrap.
REQ-029 At most one of clr_mats, po_load, at_we SHALL be high in any cycle.

Reset
REQ-030 clr low SHALL immediately force: state IDLE, all outputs 0, counters 0, coordinate (0,0), synchronizer and edge flops 0, regardless of the current state.
REQ-031 Release of clr SHALL NOT generate a button event while a button is held; a new press is required.

Verification
REQ-032 Reset, then confirm x2 -> clr_mats pulse, state 01, then po_load pulse, state 10, at_row=0, at_col=0.
REQ-033 In ATAQUE, 7 count presses -> (0,1); 35 presses from (0,0) -> (0,0).
REQ-034 hit_in=1, attacked_in=0, confirm -> one at_we pulse, hits=1, shots=1, rgb_output=10; repeat with attacked_in=1 -> no at_we, counters unchanged, rgb_output=11.
REQ-035 SHIP_CELLS=2, MAX_SHOTS=2: miss then hit -> lose=1 at shots=2; after reset, hit, hit -> win=1, state 11; confirm -> state 00, clr_mats pulse.
REQ-036 confirm and count rising in the same cycle in ATAQUE -> state CHECA, coordinate unchanged; button held 100 cycles -> exactly one event.
REQ-037 clr asserted during CHECA -> no at_we, all outputs 0 on the same cycle; held button at release -> no event.
